goal_score_keeper: RTL and testbench

//  Converts per-pixel ball/goal collision flags into debounced, one-per-goal score events.

---
 rtl/score_pkg.sv | 30 +++
 rtl/bcd2_counter.sv | 47 ++++
 rtl/goal_score_keeper.sv | 198 +++++++++++++++++++
 tb/tb_goal_score_keeper.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the goal score keeper: match states, 2-digit BCD score
// type, BCD comparison and binary-to-BCD conversion for parameter constants.
package score_pkg;

   typedef enum logic [1:0] {
      PLAYING   = 2'd0,
      GOAL_HOLD = 2'd1,
      GAME_OVER = 2'd2
   } score_state_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   function automatic logic bcd2_ge(bcd2_t a, bcd2_t b);
      return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones >= b.ones));
   endfunction

   // Parameters are given in binary; clamp to the 2-digit range before splitting.
   function automatic bcd2_t to_bcd2(logic [6:0] bin);
      bcd2_t      r;
      logic [6:0] t;
      t      = (bin > 7'd99) ? 7'd99 : bin;
      r.tens = 4'(t / 7'd10);
      r.ones = 4'(t % 7'd10);
      return r;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear; saturates at 99.
module bcd2_counter
   import score_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  clear,
   input  logic  inc,
   output bcd2_t value
);

   bcd2_t value_q, value_d;

   function automatic bcd2_t bcd2_inc_sat(bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.ones == 4'd9) begin
         if (v.tens != 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
         end
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (inc) begin
         value_d = bcd2_inc_sat(value_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/goal_score_keeper.sv
// Frame-latched goal detection, BCD scoring and match FSM for the pong scoreboard.
// Optional feature: define SCORE_BEEP_EN to generate beep_req after goals and in GAME_OVER.
module goal_score_keeper
   import score_pkg::*;
#(
   parameter logic [6:0] WIN_SCORE    = 7'd10,
   parameter logic [7:0] HOLD_FRAMES  = 8'd60,
   parameter logic [6:0] LEVEL2_SCORE = 7'd5,
   parameter logic [7:0] BEEP_FRAMES  = 8'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       goal_left,
   input  logic       goal_right,
   input  logic       restart,
   output logic [3:0] left_tens,
   output logic [3:0] left_ones,
   output logic [3:0] right_tens,
   output logic [3:0] right_ones,
   output logic       goal_pulse,
   output logic       goal_side,
   output logic       scoreLevel1,
   output logic       scoreLevel2,
   output logic       game_over,
   output logic       winner,
   output logic       beep_req
);

   localparam bcd2_t WIN_BCD    = to_bcd2(WIN_SCORE);
   localparam bcd2_t LEVEL2_BCD = to_bcd2(LEVEL2_SCORE);

   score_state_t state_q, state_d;
   logic         hit_l_q, hit_l_d;
   logic         hit_r_q, hit_r_d;
   logic [7:0]   hold_q, hold_d;
   logic         goal_pulse_q, goal_pulse_d;
   logic         goal_side_q, goal_side_d;
   logic         winner_q, winner_d;
   logic         commit, inc_left, inc_right;
   bcd2_t        left_val, right_val;

   bcd2_counter u_left_score (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .inc   (inc_left),
      .value (left_val)
   );

   bcd2_counter u_right_score (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .inc   (inc_right),
      .value (right_val)
   );

   always_comb begin
      state_d      = state_q;
      hit_l_d      = hit_l_q;
      hit_r_d      = hit_r_q;
      hold_d       = hold_q;
      goal_pulse_d = 1'b0;
      goal_side_d  = goal_side_q;
      winner_d     = winner_q;
      commit       = 1'b0;
      inc_left     = 1'b0;
      inc_right    = 1'b0;

      if (restart) begin
         state_d  = PLAYING;
         hit_l_d  = 1'b0;
         hit_r_d  = 1'b0;
         hold_d   = '0;
         winner_d = 1'b0;
      end else begin
         unique case (state_q)
            PLAYING: begin
               if (startOfFrame) begin
                  // Left-goal hit wins a same-frame tie: the right player scores.
                  if (hit_l_q) begin
                     commit      = 1'b1;
                     inc_right   = 1'b1;
                     goal_side_d = 1'b0;
                  end else if (hit_r_q) begin
                     commit      = 1'b1;
                     inc_left    = 1'b1;
                     goal_side_d = 1'b1;
                  end
                  if (commit) begin
                     state_d      = GOAL_HOLD;
                     hold_d       = HOLD_FRAMES;
                     goal_pulse_d = 1'b1;
                     hit_l_d      = 1'b0;
                     hit_r_d      = 1'b0;
                  end else begin
                     hit_l_d = goal_left;
                     hit_r_d = goal_right;
                  end
               end else begin
                  hit_l_d = hit_l_q | goal_left;
                  hit_r_d = hit_r_q | goal_right;
               end
            end
            GOAL_HOLD: begin
               hit_l_d = 1'b0;
               hit_r_d = 1'b0;
               if (startOfFrame) begin
                  if (hold_q <= 8'd1) begin
                     hold_d = '0;
                     if (left_val == WIN_BCD) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b0;
                     end else if (right_val == WIN_BCD) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b1;
                     end else begin
                        state_d = PLAYING;
                     end
                  end else begin
                     hold_d = hold_q - 8'd1;
                  end
               end
            end
            GAME_OVER: begin
               hit_l_d = 1'b0;
               hit_r_d = 1'b0;
            end
            default: begin
               state_d = PLAYING;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PLAYING;
         hit_l_q      <= 1'b0;
         hit_r_q      <= 1'b0;
         hold_q       <= '0;
         goal_pulse_q <= 1'b0;
         goal_side_q  <= 1'b0;
         winner_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         hit_l_q      <= hit_l_d;
         hit_r_q      <= hit_r_d;
         hold_q       <= hold_d;
         goal_pulse_q <= goal_pulse_d;
         goal_side_q  <= goal_side_d;
         winner_q     <= winner_d;
      end
   end

`ifdef SCORE_BEEP_EN
   logic [7:0] beep_cnt_q, beep_cnt_d;

   // A fresh goal reloads the count even if a beep is still running.
   always_comb begin
      beep_cnt_d = beep_cnt_q;
      if (restart) begin
         beep_cnt_d = '0;
      end else if (commit) begin
         beep_cnt_d = BEEP_FRAMES;
      end else if (startOfFrame && (beep_cnt_q != 8'd0)) begin
         beep_cnt_d = beep_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beep_cnt_q <= '0;
      end else begin
         beep_cnt_q <= beep_cnt_d;
      end
   end

   assign beep_req = (beep_cnt_q != 8'd0) || (state_q == GAME_OVER);
`else
   logic beep_frames_unused;
   assign beep_frames_unused = ^BEEP_FRAMES;
   assign beep_req           = 1'b0;
`endif

   assign left_tens   = left_val.tens;
   assign left_ones   = left_val.ones;
   assign right_tens  = right_val.tens;
   assign right_ones  = right_val.ones;
   assign goal_pulse  = goal_pulse_q;
   assign goal_side   = goal_side_q;
   assign scoreLevel1 = (left_val != '0) || (right_val != '0);
   assign scoreLevel2 = bcd2_ge(left_val, LEVEL2_BCD) || bcd2_ge(right_val, LEVEL2_BCD);
   assign game_over   = (state_q == GAME_OVER);
   assign winner      = winner_q;

endmodule

// File: tb/tb_goal_score_keeper.sv
// Directed bench for goal_score_keeper: vector table for frame-by-frame scoring plus
// hand-written sequences for win, restart, reset and beep corner cases.
module tb_goal_score_keeper;

   logic       clk = 1'b0;
   logic       reset, startOfFrame, goal_left, goal_right, restart;
   logic [3:0] left_tens, left_ones, right_tens, right_ones;
   logic       goal_pulse, goal_side, scoreLevel1, scoreLevel2, game_over, winner, beep_req;

`ifdef SCORE_BEEP_EN
   localparam bit BEEP_ON = 1'b1;
`else
   localparam bit BEEP_ON = 1'b0;
`endif

   goal_score_keeper #(
      .WIN_SCORE    (7'd10),
      .HOLD_FRAMES  (8'd3),
      .LEVEL2_SCORE (7'd5),
      .BEEP_FRAMES  (8'd3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .goal_left    (goal_left),
      .goal_right   (goal_right),
      .restart      (restart),
      .left_tens    (left_tens),
      .left_ones    (left_ones),
      .right_tens   (right_tens),
      .right_ones   (right_ones),
      .goal_pulse   (goal_pulse),
      .goal_side    (goal_side),
      .scoreLevel1  (scoreLevel1),
      .scoreLevel2  (scoreLevel2),
      .game_over    (game_over),
      .winner       (winner),
      .beep_req     (beep_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         gl;
      int         gr;
      logic [7:0] left;
      logic [7:0] right;
      bit         pulse;
      bit         side;
      bit         lvl1;
      bit         lvl2;
      bit         beep;
   } vec_t;

   vec_t vecs[12];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic body(input int gl, input int gr);
      for (int i = 0; i < 8; i++) begin
         goal_left  = (i < gl);
         goal_right = (i < gr);
         tick();
      end
      goal_left  = 1'b0;
      goal_right = 1'b0;
   endtask

   task automatic sof_pulse();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic frame(input int gl, input int gr);
      body(gl, gr);
      sof_pulse();
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; goal_left = 1'b0; goal_right = 1'b0; restart = 1'b0;
      //             gl gr  left   right  pulse side  lvl1  lvl2  beep
      vecs[0]  = '{3, 0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{2, 0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{0, 2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1, 1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1, 1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{0, 3, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{2, 2, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{0, 0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{0, 1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{0, 0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{0, 0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{0, 0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      repeat (3) tick();
      check("reset_digits", 32'({left_tens, left_ones, right_tens, right_ones}), 32'h0);
      check("reset_flags", 32'({goal_pulse, goal_side, scoreLevel1, scoreLevel2,
                                game_over, winner, beep_req}), 32'h0);
      reset = 1'b0;
      tick();

      // Table: one frame per record, outputs checked right after the closing startOfFrame.
      for (int k = 0; k < 12; k++) begin
         frame(vecs[k].gl, vecs[k].gr);
         check($sformatf("v%0d_left", k), 32'({left_tens, left_ones}), 32'(vecs[k].left));
         check($sformatf("v%0d_right", k), 32'({right_tens, right_ones}), 32'(vecs[k].right));
         check($sformatf("v%0d_pulse", k), 32'(goal_pulse), 32'(vecs[k].pulse));
         if (vecs[k].pulse) check($sformatf("v%0d_side", k), 32'(goal_side), 32'(vecs[k].side));
         check($sformatf("v%0d_lvl", k), 32'({scoreLevel1, scoreLevel2}),
               32'({vecs[k].lvl1, vecs[k].lvl2}));
         check($sformatf("v%0d_beep", k), 32'(beep_req), 32'(vecs[k].beep & BEEP_ON));
         check($sformatf("v%0d_gover", k), 32'(game_over), 32'h0);
         tick();
         check($sformatf("v%0d_pulse_1cyc", k), 32'(goal_pulse), 32'h0);
      end

      // Collision on the startOfFrame cycle belongs to the new frame.
      startOfFrame = 1'b1; goal_right = 1'b1;
      tick();
      startOfFrame = 1'b0; goal_right = 1'b0;
      check("sof_hit_no_commit", 32'({goal_pulse, left_tens, left_ones}), 32'h001);
      repeat (4) tick();
      sof_pulse();
      check("sof_hit_commit", 32'({goal_pulse, goal_side, left_tens, left_ones}), 32'h302);
      repeat (3) frame(0, 0);

      // Left player from 3 up to 10, crossing the BCD carry.
      for (int n = 3; n <= 10; n++) begin
         frame(0, 1);
         check($sformatf("left_to_%0d", n), 32'({goal_pulse, left_tens, left_ones}),
               32'({1'b1, to_bcd(n)}));
         check($sformatf("lvl2_at_%0d", n), 32'(scoreLevel2), 32'(n >= 5));
         for (int h = 0; h < 3; h++) begin
            frame(0, 0);
            check($sformatf("gover_%0d_h%0d", n, h), 32'(game_over), 32'((n == 10) && (h == 2)));
         end
      end
      check("winner_left", 32'(winner), 32'h0);
      check("gover_beep", 32'(beep_req), 32'(BEEP_ON));

      // Frozen in GAME_OVER.
      frame(3, 3);
      frame(0, 2);
      check("gover_frozen", 32'({goal_pulse, left_tens, left_ones, right_tens, right_ones}),
            32'h01002);
      check("gover_hold", 32'(game_over), 32'h1);

      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_digits", 32'({left_tens, left_ones, right_tens, right_ones}), 32'h0);
      check("restart_flags", 32'({game_over, scoreLevel1, beep_req}), 32'h0);
      frame(0, 1);
      check("restart_next_goal", 32'({goal_pulse, left_tens, left_ones}), 32'h101);

      // restart coincident with startOfFrame while hitR is latched.
      restart = 1'b1;
      tick();
      restart = 1'b0;
      body(0, 2);
      startOfFrame = 1'b1; restart = 1'b1;
      tick();
      startOfFrame = 1'b0; restart = 1'b0;
      check("rst_sof_scores", 32'({left_tens, left_ones, right_tens, right_ones}), 32'h0);
      check("rst_sof_pulse", 32'(goal_pulse), 32'h0);
      repeat (3) tick();
      sof_pulse();
      check("rst_sof_latch_clr", 32'({goal_pulse, left_ones}), 32'h0);

      // Beep length after a single goal.
      frame(1, 0);
      check("beep_goal", 32'({goal_pulse, right_ones, beep_req}), 32'({1'b1, 4'd1, BEEP_ON}));
      for (int f = 1; f <= 3; f++) begin
         frame(0, 0);
         check($sformatf("beep_f%0d", f), 32'(beep_req), 32'(BEEP_ON && (f < 3)));
      end

      // Reset in the middle of a hold.
      frame(1, 0);
      check("pre_reset_goal", 32'({right_tens, right_ones}), 32'h02);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midhold_reset", 32'({left_tens, left_ones, right_tens, right_ones, goal_pulse,
                                  scoreLevel1, game_over, beep_req}), 32'h0);
      frame(1, 0);
      check("post_reset_goal", 32'({goal_pulse, right_ones}), 32'h11);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
